// File: rtl/exu_wb_arbiter_pkg.sv
// Shared widths, source indices and round-robin helpers for the execute-unit write-back arbiter.
package exu_wb_arbiter_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int WB_SRC_NUM     = 3;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        SRC_LSU = 2'd0,
        SRC_CSR = 2'd1,
        SRC_MD  = 2'd2
    } wb_src_e;

    // Reduce a small sum (at most 4) modulo the number of sources.
    function automatic logic [1:0] rr_wrap(input logic [2:0] sum);
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return rr_wrap({1'b0, idx} + 3'd1);
    endfunction

endpackage

// File: rtl/exu_wb_arbiter_rr.sv
// Three-requester round-robin arbiter: search starts at the pointer, pointer moves past each winner.
module wb_rr_arb
    import exu_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WB_SRC_NUM-1:0] req,
    output logic [WB_SRC_NUM-1:0] gnt
);

    logic [1:0] ptr_reg;
    logic [1:0] ptr_next;
    logic [1:0] order_idx [WB_SRC_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < WB_SRC_NUM; gi++) begin : g_order
            assign order_idx[gi] = rr_wrap({1'b0, ptr_reg} + 3'(gi));
        end
    endgenerate

    always_comb begin
        logic found;
        gnt      = '0;
        ptr_next = ptr_reg;
        found    = 1'b0;
        for (int k = 0; k < WB_SRC_NUM; k++) begin
            if (!found && en && req[order_idx[k]]) begin
                gnt[order_idx[k]] = 1'b1;
                ptr_next          = rr_next(order_idx[k]);
                found             = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 2'd0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/exu_wb_arbiter.sv
// Write-back arbiter: ALU has fixed priority, LSU/CSR/MD share the port round-robin, and a
// starvation counter stalls ALU issue so pending multi-cycle results always drain.
module exu_wb_arbiter
    import exu_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_reg_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] alu_reg_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] alu_result_i,
    output logic                      alu_stall_o,
    input  logic                      lsu_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                      lsu_ready_o,
    input  logic                      csr_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] csr_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] csr_wdata_i,
    output logic                      csr_ready_o,
    input  logic                      md_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] md_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] md_wdata_i,
    output logic                      md_ready_o,
    output logic                      reg_we_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o,
    output logic [REG_DATA_WIDTH-1:0] reg_wdata_o
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [WB_SRC_NUM-1:0]     src_valid;
    logic [WB_SRC_NUM-1:0]     src_gnt;
    logic [REG_ADDR_WIDTH-1:0] src_waddr [WB_SRC_NUM];
    logic [REG_DATA_WIDTH-1:0] src_wdata [WB_SRC_NUM];

    logic [3:0]                starve_cnt_reg;
    logic [3:0]                starve_cnt_next;
    logic                      any_src;
    logic                      alu_gnt;
    logic                      granted;
    logic [REG_ADDR_WIDTH-1:0] sel_waddr;
    logic [REG_DATA_WIDTH-1:0] sel_wdata;

    assign src_valid = {md_valid_i, csr_valid_i, lsu_valid_i};
    assign src_waddr[SRC_LSU] = lsu_waddr_i;
    assign src_waddr[SRC_CSR] = csr_waddr_i;
    assign src_waddr[SRC_MD]  = md_waddr_i;
    assign src_wdata[SRC_LSU] = lsu_wdata_i;
    assign src_wdata[SRC_CSR] = csr_wdata_i;
    assign src_wdata[SRC_MD]  = md_wdata_i;

    assign any_src     = |src_valid;
    assign alu_stall_o = (starve_cnt_reg == STARVE_MAX) && any_src;
    // No handshakes while reset is held, so sources keep their results until it is released.
    assign alu_gnt     = alu_reg_we_i && !alu_stall_o && !rst;

    wb_rr_arb u_rr_arb (
        .clk (clk),
        .rst (rst),
        .en  (!alu_gnt && !rst),
        .req (src_valid),
        .gnt (src_gnt)
    );

    assign lsu_ready_o = src_gnt[SRC_LSU];
    assign csr_ready_o = src_gnt[SRC_CSR];
    assign md_ready_o  = src_gnt[SRC_MD];
    assign granted     = alu_gnt || (|src_gnt);

    always_comb begin
        sel_waddr = alu_reg_waddr_i;
        sel_wdata = alu_result_i;
        for (int i = 0; i < WB_SRC_NUM; i++) begin
            if (src_gnt[i]) begin
                sel_waddr = src_waddr[i];
                sel_wdata = src_wdata[i];
            end
        end
    end

    // Counts ALU wins over a waiting source; any other cycle means the sources are not starving.
    always_comb begin
        starve_cnt_next = 4'd0;
        if (alu_gnt && any_src) begin
            starve_cnt_next = (starve_cnt_reg == STARVE_MAX) ? starve_cnt_reg
                                                             : starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= 4'd0;
            reg_we_o       <= WRITE_DISABLE;
            reg_waddr_o    <= '0;
            reg_wdata_o    <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            reg_we_o       <= (granted && (sel_waddr != '0)) ? WRITE_ENABLE : WRITE_DISABLE;
            if (granted) begin
                reg_waddr_o <= sel_waddr;
                reg_wdata_o <= sel_wdata;
            end
        end
    end

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Randomised scoreboard bench for exu_wb_arbiter with a behavioural grant model.
module tb_exu_wb_arbiter;
    import exu_wb_arbiter_pkg::*;

    localparam int LIMIT = 4;
    localparam int AW    = REG_ADDR_WIDTH;
    localparam int DW    = REG_DATA_WIDTH;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_we = 1'b0;
    logic [AW-1:0] alu_waddr = '0;
    logic [DW-1:0] alu_data = '0;
    logic          sv [3];
    logic [AW-1:0] sa [3];
    logic [DW-1:0] sd [3];
    logic          alu_stall_o, lsu_ready_o, csr_ready_o, md_ready_o;
    logic          reg_we_o;
    logic [AW-1:0] reg_waddr_o;
    logic [DW-1:0] reg_wdata_o;

    int  checks = 0;
    int  failures = 0;
    int  prot_viol = 0;
    int  m_ptr = 0;
    int  m_starve = 0;
    wr_t sb [$];

    always #5 clk = ~clk;

    exu_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_reg_we_i    (alu_we),
        .alu_reg_waddr_i (alu_waddr),
        .alu_result_i    (alu_data),
        .alu_stall_o     (alu_stall_o),
        .lsu_valid_i     (sv[0]),
        .lsu_waddr_i     (sa[0]),
        .lsu_wdata_i     (sd[0]),
        .lsu_ready_o     (lsu_ready_o),
        .csr_valid_i     (sv[1]),
        .csr_waddr_i     (sa[1]),
        .csr_wdata_i     (sd[1]),
        .csr_ready_o     (csr_ready_o),
        .md_valid_i      (sv[2]),
        .md_waddr_i      (sa[2]),
        .md_wdata_i      (sd[2]),
        .md_ready_o      (md_ready_o),
        .reg_we_o        (reg_we_o),
        .reg_waddr_o     (reg_waddr_o),
        .reg_wdata_o     (reg_wdata_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Protocol monitor: dispatch must not present an ALU result while stalled.
    always @(negedge clk) begin
        if (!rst && alu_we && alu_stall_o) prot_viol++;
    end

    // Monitor: every register-file write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reg_we_o) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write actual=x%0d/0x%0h expected=none", reg_waddr_o, reg_wdata_o);
                end else begin
                    e = sb.pop_front();
                    if (reg_waddr_o !== e.a || reg_wdata_o !== e.d) begin
                        failures++;
                        $display("FAIL write actual=x%0d/0x%0h expected=x%0d/0x%0h",
                                 reg_waddr_o, reg_wdata_o, e.a, e.d);
                    end else begin
                        $display("write x%0d <= 0x%0h", reg_waddr_o, reg_wdata_o);
                    end
                end
            end
        end
    end

    function automatic bit model_stall();
        return (m_starve == LIMIT) && (sv[0] || sv[1] || sv[2]);
    endfunction

    // One clock cycle: entered at posedge+1 with inputs driven, returns at next posedge+1.
    task automatic step();
        bit         any, stall, alu_g, in_rst;
        int         win;
        int         idx;
        logic [3:0] exp_vec;
        wr_t        w;
        in_rst  = rst;
        any     = sv[0] || sv[1] || sv[2];
        stall   = model_stall();
        alu_g   = alu_we && !stall && !in_rst;
        win     = -1;
        if (!alu_g && !in_rst) begin
            for (int k = 0; k < 3; k++) begin
                idx = (m_ptr + k) % 3;
                if (win < 0 && sv[idx]) win = idx;
            end
        end
        exp_vec = {stall, win == 2, win == 1, win == 0};
        @(negedge clk);
        check("stall_ready", {alu_stall_o, md_ready_o, csr_ready_o, lsu_ready_o}, exp_vec);
        if (in_rst) begin
            m_ptr    = 0;
            m_starve = 0;
        end else begin
            if (alu_g) begin
                w.a = alu_waddr; w.d = alu_data;
                if (w.a != 0) sb.push_back(w);
            end else if (win >= 0) begin
                w.a = sa[win]; w.d = sd[win];
                if (w.a != 0) sb.push_back(w);
                m_ptr = (win + 1) % 3;
            end
            m_starve = (alu_g && any) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        end
        @(posedge clk);
        #1;
        if (win >= 0) sv[win] = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sv[i] = 1'b1; sa[i] = a; sd[i] = d;
    endtask

    initial begin
        int first_stall;
        for (int i = 0; i < 3; i++) begin sv[i] = 1'b0; sa[i] = '0; sd[i] = '0; end

        // Reset state
        #2;
        check("reset_outputs", {alu_stall_o, reg_we_o, reg_waddr_o, reg_wdata_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU only, back to back
        for (int i = 0; i < 4; i++) begin
            alu_we = 1'b1; alu_waddr = 5'd5; alu_data = 32'h1234 + i;
            step();
        end
        alu_we = 1'b0;

        // Round-robin among all three sources
        set_src(0, 5'd1, 32'hA);
        set_src(1, 5'd2, 32'hB);
        set_src(2, 5'd3, 32'hC);
        for (int i = 0; i < 4; i++) step();

        // Starvation: ALU every cycle against a waiting MD
        set_src(2, 5'd7, 32'hC0DE);
        first_stall = -1;
        for (int i = 0; i < 7; i++) begin
            if (first_stall < 0 && alu_stall_o) first_stall = i;
            alu_we = !model_stall(); alu_waddr = 5'd9; alu_data = 32'h100 + i;
            step();
        end
        alu_we = 1'b0;
        check("stall_after_limit", first_stall, LIMIT);

        // x0 destination is handshaken but not written
        set_src(1, 5'd0, 32'hFFFF);
        step();
        check("x0_no_write", reg_we_o, 1'b0);

        // Protocol: ALU asserted while stalled is ignored and flagged
        set_src(2, 5'd8, 32'hBEEF);
        for (int i = 0; i < LIMIT; i++) begin
            alu_we = 1'b1; alu_waddr = 5'd4; alu_data = 32'h200 + i;
            step();
        end
        alu_we = 1'b1; alu_waddr = 5'd10; alu_data = 32'hDEAD;
        step();
        alu_we = 1'b0;
        check("protocol_flag", prot_viol, 1);

        // Reset in the middle of a pending write
        alu_we = 1'b1; alu_waddr = 5'd12; alu_data = 32'h5555;
        step();
        alu_we = 1'b0;
        set_src(0, 5'd11, 32'h7777);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midreset_outputs", {alu_stall_o, reg_we_o, reg_waddr_o, reg_wdata_o}, 64'd0);
        step();
        rst = 1'b0;
        step();

        // Randomised traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!sv[i] && $urandom_range(0, 9) < 4) begin
                    set_src(i, ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom), DW'($urandom));
                end
            end
            alu_we    = !model_stall() && ($urandom_range(0, 1) == 1);
            alu_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
            alu_data  = DW'($urandom);
            step();
        end
        alu_we = 1'b0;
        for (int c = 0; c < 10 && (sv[0] || sv[1] || sv[2]); c++) step();
        check("sources_drained", {sv[0], sv[1], sv[2]}, 3'b000);
        step();
        step();
        check("scoreboard_empty", sb.size(), 0);
        check("no_protocol_errors", prot_viol, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exu_wb_arbiter.md
# exu_wb_arbiter

Write-back arbiter directly downstream of the ALU result path in the execute unit. Merges the single-cycle ALU result with the multi-cycle result sources (LSU load return, CSR read, MUL/DIV) onto the one register-file write port and registers the winning write. Fixed ALU priority, round-robin among the other sources, and a starvation counter that briefly stalls ALU issue so queued results always drain.

## Interface
- STARVE_LIMIT, 4: consecutive cycles a pending non-ALU source may lose to the ALU before the ALU is stalled (1..15).
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- alu_reg_we_i  in  1  ALU result valid (ALU write enable); never back-pressured
- alu_reg_waddr_i  in  `REG_ADDR_WIDTH  ALU destination
- alu_result_i  in  `REG_DATA_WIDTH  ALU result
- alu_stall_o  out  1  dispatch must not issue an ALU op this cycle
- lsu_valid_i / csr_valid_i / md_valid_i  in  1 each  source result valid
- lsu_waddr_i / csr_waddr_i / md_waddr_i  in  `REG_ADDR_WIDTH each  destination
- lsu_wdata_i / csr_wdata_i / md_wdata_i  in  `REG_DATA_WIDTH each  data
- lsu_ready_o / csr_ready_o / md_ready_o  out  1 each  result accepted this cycle
- reg_we_o  out  1  register-file write enable
- reg_waddr_o  out  `REG_ADDR_WIDTH  write address
- reg_wdata_o  out  `REG_DATA_WIDTH  write data

## Operation
- Source handshake: a transfer occurs when valid_i && ready_o in the same cycle; the source holds waddr/wdata stable while valid and unaccepted.
- Grant per cycle, at most one:
  - alu_reg_we_i=1 and alu_stall_o=0 → ALU granted; all ready_o=0.
  - Otherwise the round-robin winner among valid LSU/CSR/MD is granted (its ready_o=1).
- Round-robin: 2-bit pointer, order LSU→CSR→MD; search starts at pointer; after a non-ALU grant, pointer = granted index+1 (mod 3). Pointer unchanged on ALU grant or idle.
- Starvation counter starve_cnt (4 bits): increments (saturating at STARVE_LIMIT) each cycle the ALU is granted while any non-ALU valid is high; clears on any non-ALU grant or when no non-ALU valid.
- alu_stall_o = (starve_cnt == STARVE_LIMIT) && (any non-ALU valid). Combinational from registered state. When stalled, alu_reg_we_i is ignored; asserting it while stalled is a protocol error (bench assertion).
- Destination x0: granted and handshaken normally, but reg_we_o stays 0.
- Output register: reg_we_o <= granted && waddr!=0; reg_waddr_o/reg_wdata_o load the granted source's values on grant, hold otherwise.

## Timing
- Reset (async, immediate): reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, pointer=0 (LSU), starve_cnt=0 → alu_stall_o=0; ready_o follow their combinational equations.
- Latency: accepted result appears on reg_we_o/reg_waddr_o/reg_wdata_o exactly 1 cycle after the grant cycle; throughput one write per cycle.
- ready_o is combinational from valid inputs and registered state; no valid→ready→valid loop is permitted in sources.
- Simultaneous ALU + all three sources with starve_cnt<limit: ALU wins; counter increments.
- Counter at limit: stall cycle grants the RR winner, counter clears next cycle.
- Reset asserted mid-transfer: the pending output write is discarded; sources must re-present.

## Structure
- `REG_DATA_WIDTH, `REG_ADDR_WIDTH, `WriteEnable/`WriteDisable, and a new `WB_SRC_NUM (3) constant belong in defines.v.
- One sub-module: wb_rr_arb (3-requester round-robin arbiter with pointer register, one-hot grant out); starvation counter and output register stay in the top.

## Test plan
- Reset: assert rst mid-cycle with lsu_valid_i=1 → all outputs 0 immediately, lsu_ready_o only after rst falls, first write 1 cycle later.
- ALU only: alu_reg_we_i=1, waddr=5, result=0x1234 → next cycle reg_we_o=1, waddr=5, wdata=0x1234; back-to-back every cycle.
- Round-robin: LSU(x1,0xA), CSR(x2,0xB), MD(x3,0xC) valid together, no ALU → writes x1,x2,x3 on three consecutive cycles; ready pulses once each.
- Starvation: ALU valid every cycle, MD valid x7 → alu_stall_o rises after 4 ALU grants; MD granted that cycle; x7 written next cycle; counter back to 0.
- x0 drop: CSR valid waddr=0 wdata=0xFFFF → csr_ready_o=1, reg_we_o stays 0.
- Protocol: alu_reg_we_i=1 while alu_stall_o=1 → assertion fires; ALU input ignored.
